// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions.
// Holds the opcode and funct constants the decoder and fetch unit agree on, the
// PCSrc encoding used for redirects, the fetch FSM state encoding and the
// {pc, instr} entry type carried through the fetch buffer.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Decoder PCSrc encoding; 2'b11 never names a redirect
  localparam logic [1:0] PCSRC_BR   = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_REG  = 2'b10;
  localparam logic [1:0] PCSRC_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries for the fetch front end.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   flush           empties the FIFO on the next edge (wins over push/pop)
//   push, push_data write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head_data       current head entry (registered storage)
//   full, empty     occupancy flags
//   count           number of valid entries
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  // A depth of one still needs a one-bit pointer to keep the declarations legal.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end feeding the control decoder.
// Owns the PC, issues word fetches over a valid/ready request channel, buffers
// in-order responses in fetch_fifo and presents the head to the decoder with a
// valid/ready handshake. Redirects (branch, jump, register) flush the buffer,
// retarget the PC and discard responses still in flight.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order read data, no backpressure
//   instr_valid/ready                decoder handshake
//   instr, instr_pc, opcode, funct   head instruction and its fields
//   redir_valid/pcsrc/pc/jidx/
//   redir_reg_tgt/redir_br_tgt       redirect request and target sources
//   misalign_err                     one-cycle pulse after a misaligned target
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  input  logic        redir_valid,
  input  logic [1:0]  redir_pcsrc,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_jidx,
  input  logic [31:0] redir_reg_tgt,
  input  logic [31:0] redir_br_tgt,
  output logic        misalign_err
);

  localparam int             CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]    DEPTH_W = (CW + 1)'(BUF_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          misalign_err_q, misalign_err_d;

  logic          req_hs;
  logic          redir_take;
  logic [31:0]   redir_target;
  logic [3:0]    pc4_hi;
  logic [27:0]   pc4_unused;
  logic [CW:0]   in_flight;

  logic          fifo_push, fifo_pop;
  logic          fifo_full_unused, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry, head_entry;

  // Only the top nibble of redir_pc + 4 contributes to a j/jal target.
  assign {pc4_hi, pc4_unused} = redir_pc + 32'd4;

  // PCSrc 2'b11 is not a redirect at all; it must leave every piece of state alone.
  assign redir_take = redir_valid && (redir_pcsrc != PCSRC_RSVD);

  always_comb begin
    redir_target = redir_br_tgt;
    case (redir_pcsrc)
      PCSRC_JUMP: redir_target = {pc4_hi, redir_jidx, 2'b00};
      PCSRC_REG:  redir_target = redir_reg_tgt;
      default:    redir_target = redir_br_tgt;
    endcase
  end

  // Buffered words plus words still in flight may never exceed the buffer, which
  // is what guarantees every accepted response has a free FIFO slot.
  assign in_flight      = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = (state_q == S_RUN) && (in_flight < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // With discard at zero every outstanding request was issued consecutively from
  // the current PC backwards, so the oldest one (the one answering now) sits at
  // pc - 4*outstanding. This avoids storing addresses per request.
  assign push_entry.pc    = pc_q - {{(30 - CW){1'b0}}, outstanding_q, 2'b00};
  assign push_entry.instr = imem_rsp_data;

  // A response landing in a redirect cycle belongs to the old stream.
  assign fifo_push = imem_rsp_valid && (discard_q == '0) && !redir_take;

  // No decoder handshake may complete in a redirect cycle.
  assign instr_valid = !fifo_empty && !redir_valid;
  assign fifo_pop    = instr_valid && instr_ready;

  assign instr        = head_entry.instr;
  assign instr_pc     = head_entry.pc;
  assign opcode       = head_entry.instr[31:26];
  assign funct        = head_entry.instr[5:0];
  assign misalign_err = misalign_err_q;

  // Next-state logic: counters, PC, FSM and the misalignment pulse. A redirect
  // sets discard to everything that will still be outstanding after this edge,
  // and goes straight back to S_RUN when nothing is left to drain.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    outstanding_d  = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
    discard_d      = discard_q;
    misalign_err_d = 1'b0;

    if (req_hs) begin
      pc_d = pc_q + 32'd4;
    end

    if (imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_DRAIN: state_d = (discard_d == '0) ? S_RUN : S_DRAIN;
      default: state_d = S_BOOT;
    endcase

    if (redir_take) begin
      pc_d           = {redir_target[31:2], 2'b00};
      discard_d      = outstanding_d;
      misalign_err_d = (redir_target[1:0] != 2'b00);
      state_d        = (outstanding_d == '0) ? S_RUN : S_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_BOOT;
      pc_q           <= RESET_PC;
      outstanding_q  <= '0;
      discard_q      <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redir_take),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head_data(head_entry),
    .full     (fifo_full_unused),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit (RESET_PC = 0, BUF_DEPTH = 2).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge. A small fixed-latency memory answers every accepted request in order
// with data = addr ^ 32'hAC00_0015, and logs request and pop addresses.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_pcsrc = 2'b00;
  logic [31:0] redir_pc = '0;
  logic [25:0] redir_jidx = '0;
  logic [31:0] redir_reg_tgt = '0;
  logic [31:0] redir_br_tgt = '0;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_req_t;

  mem_req_t    pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_ins_log[$];

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .opcode        (opcode),
    .funct         (funct),
    .redir_valid   (redir_valid),
    .redir_pcsrc   (redir_pcsrc),
    .redir_pc      (redir_pc),
    .redir_jidx    (redir_jidx),
    .redir_reg_tgt (redir_reg_tgt),
    .redir_br_tgt  (redir_br_tgt),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hAC00_0015;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Memory model and transaction monitor, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    mem_req_t r;
    if (reset) begin
      pend_q.delete();
      req_log.delete();
      pop_pc_log.delete();
      pop_ins_log.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        r.due  = cyc + mem_lat;
        r.addr = imem_req_addr;
        pend_q.push_back(r);
        req_log.push_back(imem_req_addr);
      end
      if (instr_valid && instr_ready) begin
        pop_pc_log.push_back(instr_pc);
        pop_ins_log.push_back(instr);
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs just after the edge, returns at the falling edge.
  task automatic apply_stimulus(input logic rv, input logic [1:0] src,
                                input logic [31:0] rpc, input logic [25:0] jidx,
                                input logic [31:0] rtgt, input logic [31:0] btgt,
                                input logic rdy);
    @(posedge clk);
    #1;
    redir_valid   = rv;
    redir_pcsrc   = src;
    redir_pc      = rpc;
    redir_jidx    = jidx;
    redir_reg_tgt = rtgt;
    redir_br_tgt  = btgt;
    instr_ready   = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) apply_stimulus(1'b0, 2'b00, '0, '0, '0, '0, rdy);
  endtask

  // Leaves the bench at the falling edge of the first cycle after release (S_BOOT).
  task automatic do_reset(input int lat, input logic rdy);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    redir_valid = 1'b0;
    instr_ready = rdy;
    mem_lat     = lat;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // 1: streaming with a 1-cycle memory
    do_reset(1, 1'b1);
    check_output("t1_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_output("t1_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check_output("t1_rst_misalign", {31'b0, misalign_err}, 32'd0);
    idle(1, 1'b1);
    check_output("t1_c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_output("t1_c1_req_addr", imem_req_addr, 32'h0);
    idle(1, 1'b1);
    check_output("t1_c2_req_addr", imem_req_addr, 32'h4);
    check_output("t1_c2_instr_valid", {31'b0, instr_valid}, 32'd0);
    idle(1, 1'b1);
    check_output("t1_c3_instr_valid", {31'b0, instr_valid}, 32'd1);
    check_output("t1_c3_instr_pc", instr_pc, 32'h0);
    check_output("t1_c3_instr", instr, 32'hAC00_0015);
    check_output("t1_c3_opcode", {26'b0, opcode}, 32'h2B);
    check_output("t1_c3_funct", {26'b0, funct}, 32'h15);
    check_output("t1_c3_req_valid", {31'b0, imem_req_valid}, 32'd0);
    idle(12, 1'b1);
    #2;
    check_output("t1_req0", q_at(req_log, 0), 32'h0);
    check_output("t1_req1", q_at(req_log, 1), 32'h4);
    check_output("t1_req2", q_at(req_log, 2), 32'h8);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t1_pop_pc%0d", i), q_at(pop_pc_log, i), 32'(4 * i));
      check_output($sformatf("t1_pop_ins%0d", i), q_at(pop_ins_log, i),
                   mem_word(32'(4 * i)));
    end

    // 2: decoder stall, then a PCSrc=11 pulse that must change nothing
    do_reset(1, 1'b0);
    idle(5, 1'b0);
    check_output("t2_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_output("t2_full_instr_valid", {31'b0, instr_valid}, 32'd1);
    check_output("t2_full_instr_pc", instr_pc, 32'h0);
    #2;
    check_output("t2_req_count", 32'(req_log.size()), 32'd2);
    apply_stimulus(1'b1, 2'b11, 32'h0, 26'h3FF_FFFF, 32'h0000_5002, 32'h0000_6000, 1'b0);
    check_output("t2_rsvd_instr_valid", {31'b0, instr_valid}, 32'd0);
    idle(1, 1'b0);
    check_output("t2_rsvd_after_valid", {31'b0, instr_valid}, 32'd1);
    check_output("t2_rsvd_after_pc", instr_pc, 32'h0);
    check_output("t2_rsvd_after_req", {31'b0, imem_req_valid}, 32'd0);
    check_output("t2_rsvd_misalign", {31'b0, misalign_err}, 32'd0);
    idle(12, 1'b1);
    #2;
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("t2_pop_pc%0d", i), q_at(pop_pc_log, i), 32'(4 * i));
    end
    check_output("t2_req2", q_at(req_log, 2), 32'h8);

    // 3: jump while the head is valid and a response lands in the redirect cycle
    do_reset(1, 1'b1);
    idle(2, 1'b1);
    apply_stimulus(1'b1, 2'b01, 32'h0040_0010, 26'h000_0100, '0, '0, 1'b1);
    check_output("t3_redir_instr_valid", {31'b0, instr_valid}, 32'd0);
    idle(1, 1'b1);
    check_output("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_output("t3_req_addr", imem_req_addr, 32'h0000_0400);
    check_output("t3_instr_valid_after", {31'b0, instr_valid}, 32'd0);
    idle(8, 1'b1);
    #2;
    check_output("t3_pop_pc0", q_at(pop_pc_log, 0), 32'h0000_0400);
    check_output("t3_pop_ins0", q_at(pop_ins_log, 0), 32'hAC00_0415);
    check_output("t3_req2", q_at(req_log, 2), 32'h0000_0400);

    // 3b: jump whose redir_pc + 4 carries into the top nibble
    do_reset(1, 1'b1);
    apply_stimulus(1'b1, 2'b01, 32'h1FFF_FFFC, 26'h000_0040, '0, '0, 1'b1);
    idle(2, 1'b1);
    check_output("t3b_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_output("t3b_req_addr", imem_req_addr, 32'h2000_0100);

    // 4: misaligned jr target with one request in flight
    do_reset(1, 1'b1);
    apply_stimulus(1'b1, 2'b10, '0, '0, 32'h0000_1002, '0, 1'b1);
    check_output("t4_c1_misalign", {31'b0, misalign_err}, 32'd0);
    idle(1, 1'b1);
    check_output("t4_c2_misalign", {31'b0, misalign_err}, 32'd1);
    check_output("t4_c2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    idle(1, 1'b1);
    check_output("t4_c3_misalign", {31'b0, misalign_err}, 32'd0);
    check_output("t4_c3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_output("t4_c3_req_addr", imem_req_addr, 32'h0000_1000);
    idle(8, 1'b1);
    #2;
    check_output("t4_pop_pc0", q_at(pop_pc_log, 0), 32'h0000_1000);
    check_output("t4_req1", q_at(req_log, 1), 32'h0000_1000);

    // 5: 3-cycle memory, two requests in flight, back-to-back redirects
    do_reset(3, 1'b1);
    idle(2, 1'b1);
    apply_stimulus(1'b1, 2'b00, '0, '0, '0, 32'h0000_2000, 1'b1);
    check_output("t5_c3_req_valid", {31'b0, imem_req_valid}, 32'd0);
    apply_stimulus(1'b1, 2'b10, '0, '0, 32'h0000_3000, '0, 1'b1);
    check_output("t5_c4_req_valid", {31'b0, imem_req_valid}, 32'd0);
    idle(1, 1'b1);
    check_output("t5_c5_req_valid", {31'b0, imem_req_valid}, 32'd0);
    idle(1, 1'b1);
    check_output("t5_c6_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_output("t5_c6_req_addr", imem_req_addr, 32'h0000_3000);
    idle(10, 1'b1);
    #2;
    check_output("t5_pop_pc0", q_at(pop_pc_log, 0), 32'h0000_3000);
    check_output("t5_pop_ins0", q_at(pop_ins_log, 0), 32'hAC00_3015);
    check_output("t5_req2", q_at(req_log, 2), 32'h0000_3000);

    // 6: asynchronous reset with the buffer full
    do_reset(1, 1'b0);
    idle(4, 1'b0);
    check_output("t6_full_instr_valid", {31'b0, instr_valid}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_output("t6_async_instr_valid", {31'b0, instr_valid}, 32'd0);
    check_output("t6_async_misalign", {31'b0, misalign_err}, 32'd0);
    check_output("t6_async_instr", instr, 32'h0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    check_output("t6_boot_req_valid", {31'b0, imem_req_valid}, 32'd0);
    idle(1, 1'b1);
    check_output("t6_c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_output("t6_c1_req_addr", imem_req_addr, 32'h0);
    idle(1, 1'b1);
    #2;
    check_output("t6_req0", q_at(req_log, 0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
